// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/func constants, reset vector, fetch FSM
// encoding and the next-PC request bundle.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        branch;
    logic        jump;
    logic        zero;
  } npc_req_t;

  // Word offset of a branch: sign-extended imm16 scaled to bytes.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC: jump beats taken branch beats sequential.
// All adds wrap naturally at 32 bits; result is always word aligned.
module npc_calc
  import cpu_pkg::*;
(
  input  npc_req_t    req,
  output logic [31:0] npc
);

  logic [31:0] seq;
  logic [31:0] jmp_tgt;
  logic [31:0] br_tgt;

  assign seq     = req.pc + 32'd4;
  // Jump keeps the region bits of the sequential PC, not of the current PC.
  assign jmp_tgt = {seq[31:28], req.ir[25:0], 2'b00};
  assign br_tgt  = seq + br_offset(req.ir[15:0]);

  always_comb begin
    npc = seq;
    if (req.jump)                  npc = jmp_tgt;
    else if (req.branch && req.zero) npc = br_tgt;
    npc[1:0] = 2'b00;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/ISSUE sequencer owning PC, IR and the
// retired-instruction counter.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        Jump,
  input  logic        zero,
  output logic [31:0] retired
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  ir;
  logic [31:0]  npc;
  npc_req_t     nreq;

  assign nreq = '{pc: pc_q, ir: ir, branch: branch, jump: Jump, zero: zero};

  npc_calc u_npc (
    .req (nreq),
    .npc (npc)
  );

  // imem_req and instr_valid are registered alongside the state so they are
  // glitch-free and exactly track FETCH / ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      ir          <= '0;
      retired     <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            state       <= ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (exec_done) begin
            pc_q        <= {npc[31:2], 2'b00};
            retired     <= retired + 32'd1;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign op        = ir[31:26];
  assign func      = ir[5:0];
  assign imm16     = ir[15:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetched instructions go through a
// scoreboard, next-PC results are checked against a small reference model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst, rst_w;
  logic        imem_ack, exec_done, branch, jmp, zero;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc, retired;
  logic [5:0]  op, func;
  logic [15:0] imm16;

  logic        w_ack, w_exec;
  logic [31:0] w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_ret;
  logic [5:0]  w_op, w_func;
  logic [15:0] w_imm;

  always #5 clk = ~clk;

  ifetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .op(op), .func(func), .imm16(imm16), .pc(pc), .exec_done(exec_done),
    .branch(branch), .Jump(jmp), .zero(zero), .retired(retired)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst_w), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .instr_valid(w_valid),
    .op(w_op), .func(w_func), .imm16(w_imm), .pc(w_pc), .exec_done(w_exec),
    .branch(1'b0), .Jump(1'b0), .zero(1'b0), .retired(w_ret)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } fx_t;

  fx_t         sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc, m_ret, m_ir;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected next PC, written from the ISA description.
  function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] ir,
                                            input logic b, input logic j, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(ir[15:0])) * 4;
    if (j)           return (seq & 32'hF000_0000) | ({6'b0, ir[25:0]} << 2);
    else if (b && z) return seq + 32'(off);
    return seq;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_ret", retired, 32'd0);
    rst = 1'b0;
    tick();
    m_pc  = 32'h0000_3000;
    m_ret = 32'd0;
  endtask

  // Assumes FETCH at entry; holds ack low for dly cycles, then acks with word.
  task automatic fetch(input logic [31:0] word, input int dly);
    fx_t f, got;
    int  req_cycles;
    req_cycles = 0;
    for (int i = 0; i < dly; i++) begin
      if (imem_req) req_cycles++;
      chk("hold_addr", imem_addr, m_pc);
      exec_done = 1'b1;               // must be ignored outside ISSUE
      tick();
      exec_done = 1'b0;
    end
    if (imem_req) req_cycles++;
    chk("ack_addr", imem_addr, m_pc);
    imem_ack   = 1'b1;
    imem_rdata = word;
    f.pc = m_pc;
    f.ir = word;
    sb.push_back(f);
    tick();
    imem_ack = 1'b0;
    chk("req_cycles", 32'(req_cycles), 32'(dly + 1));
    chk("req_low", {31'b0, imem_req}, 32'd0);
    chk("pc_stable", pc, m_pc);
    chk("ret_stable", retired, m_ret);
    chk("valid", {31'b0, instr_valid}, 32'd1);
    if (instr_valid && sb.size() > 0) begin
      got = sb.pop_front();
      chk("sb_op", {26'b0, op}, {26'b0, got.ir[31:26]});
      chk("sb_func", {26'b0, func}, {26'b0, got.ir[5:0]});
      chk("sb_imm", {16'b0, imm16}, {16'b0, got.ir[15:0]});
      chk("sb_pc", pc, got.pc);
    end
    m_ir = word;
  endtask

  // Assumes ISSUE at entry.
  task automatic retire(input logic b, input logic j, input logic z);
    logic [31:0] exp;
    exp = model_npc(m_pc, m_ir, b, j, z);
    chk("valid_at_done", {31'b0, instr_valid}, 32'd1);
    exec_done = 1'b1;
    branch    = b;
    jmp       = j;
    zero      = z;
    tick();
    {exec_done, branch, jmp, zero} = 4'b0;
    m_pc  = exp;
    m_ret = m_ret + 32'd1;
    chk("npc", pc, m_pc);
    chk("retired", retired, m_ret);
    chk("valid_drop", {31'b0, instr_valid}, 32'd0);
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    {imem_ack, exec_done, branch, jmp, zero} = 5'b0;
    imem_rdata = '0;
    w_ack = 1'b0; w_exec = 1'b0; w_rdata = '0;
    m_pc = 32'h0000_3000; m_ret = '0; m_ir = '0;
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_ret", retired, 32'd0);
    chk("rst_ir", {op, func, imm16}, 28'd0);
    chk("w_rst_pc", w_pc, 32'hFFFF_FFFC);

    // Wrap instance: one sequential retire from the top of memory.
    rst_w = 1'b0;
    tick();
    chk("w_req", {31'b0, w_req}, 32'd1);
    chk("w_addr", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h0000_0020;
    tick();
    w_ack = 1'b0;
    chk("w_valid", {31'b0, w_valid}, 32'd1);
    w_exec = 1'b1;
    tick();
    w_exec = 1'b0;
    chk("w_pc_wrap", w_pc, 32'h0000_0000);
    chk("w_ret", w_ret, 32'd1);

    // Zero-wait fetch of an add at the reset vector.
    rst = 1'b0;
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    fetch(32'h0000_0020, 0);
    chk("add_op", {26'b0, op}, 32'h0);
    chk("add_func", {26'b0, func}, 32'h20);

    // Stray ack during ISSUE must not reload IR.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("ack_in_issue", {26'b0, func}, 32'h20);
    retire(1'b0, 1'b0, 1'b0);

    // Delayed ack: request and address held for four cycles.
    do_reset();
    fetch(32'h0000_0020, 3);
    chk("delay_addr", pc, 32'h0000_3000);
    retire(1'b0, 1'b0, 1'b0);

    // Branch backward taken from 0x3008, then not taken.
    fetch(32'h0000_0022, 0);
    retire(1'b0, 1'b0, 1'b1);
    fetch(32'h1000_FFFE, 0);
    retire(1'b1, 1'b0, 1'b1);
    chk("br_taken", pc, 32'h0000_3004);
    fetch(32'h0000_0020, 1);
    retire(1'b0, 1'b0, 1'b0);
    fetch(32'h1000_FFFE, 0);
    retire(1'b1, 1'b0, 1'b0);
    chk("br_not_taken", pc, 32'h0000_300C);

    // Jump with branch also asserted from 0x3010.
    fetch(32'h0000_0020, 0);
    retire(1'b0, 1'b0, 1'b0);
    fetch(32'h0800_0C10, 2);
    retire(1'b1, 1'b1, 1'b1);
    chk("jump", pc, 32'h0000_3040);

    // Reset during FETCH with a coincident ack.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    chk("rstf_ir", {op, func, imm16}, 28'd0);
    chk("rstf_pc", pc, 32'h0000_3000);
    chk("rstf_ret", retired, 32'd0);
    chk("rstf_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    m_pc = 32'h0000_3000; m_ret = '0;

    // exec_done coincident with reset is discarded.
    fetch(32'h0800_0C10, 0);
    rst = 1'b1; exec_done = 1'b1; jmp = 1'b1;
    tick();
    rst = 1'b0; exec_done = 1'b0; jmp = 1'b0;
    chk("rste_pc", pc, 32'h0000_3000);
    chk("rste_ret", retired, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-006 SHALL have port imem_ack  input  1  read data valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 SHALL have port instr_valid  output  1  instruction register holds an instruction for the controller/datapath.
REQ-009 SHALL have port op  output  6  IR[31:26], to the control unit.
REQ-010 SHALL have port func  output  6  IR[5:0], to the control unit.
REQ-011 SHALL have port imm16  output  16  IR[15:0].
REQ-012 SHALL have port pc  output  32  address of the instruction in IR.
REQ-013 SHALL have port exec_done  input  1  datapath retires the current instruction this cycle.
REQ-014 SHALL have ports branch, Jump, zero  input  1 each  control-unit branch/jump decisions and ALU zero flag, sampled with exec_done.
REQ-015 SHALL have port retired  output  32  count of retired instructions.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, ISSUE; IDLE->FETCH unconditionally; FETCH->ISSUE on imem_ack; ISSUE->FETCH on exec_done.
REQ-017 SHALL assert imem_req only in FETCH, with imem_addr=pc held stable until imem_ack.
REQ-018 SHALL accept imem_ack in the same cycle imem_req first rises (zero-wait memory allowed).
REQ-019 SHALL latch imem_rdata into IR on the FETCH cycle with imem_ack=1; instr_valid=1 from the next cycle through the exec_done cycle.
REQ-020 SHALL ignore imem_ack outside FETCH and exec_done outside ISSUE.
REQ-021 SHALL compute next PC on exec_done: Jump=1 -> {pc+4[31:28], IR[25:0], 2'b00}; else branch&zero -> pc+4+(sign-extended imm16<<2); else pc+4.
REQ-022 SHALL give Jump priority over branch when both are 1.
REQ-023 SHALL wrap all PC arithmetic modulo 2^32 (pc=32'hFFFF_FFFC, sequential -> 32'h0000_0000).
REQ-024 SHALL force pc[1:0]=2'b00 at all times.
REQ-025 SHALL increment retired on each accepted exec_done, wrapping 32'hFFFF_FFFF -> 0.
REQ-026 SHALL give minimum instruction period 2 cycles (FETCH with immediate ack + ISSUE with immediate exec_done).

Reset
REQ-027 SHALL on rst: state=IDLE, pc=RESET_PC, IR=0, retired=0, imem_req=0, instr_valid=0.
REQ-028 SHALL abandon an in-flight fetch on rst; imem_ack in the reset cycle SHALL not load IR.
REQ-029 SHALL discard exec_done coincident with rst (no PC update, no count).

Structure
REQ-030 SHALL take opcode constants, RESET_PC default and FSM state encoding from shared package cpu_pkg.
REQ-031 SHALL place next-PC computation (REQ-021..REQ-024) in combinational sub-module npc_calc.

Verification
REQ-032 SHALL cover: reset, imem_ack in first FETCH cycle with 32'h0000_0020 (add) -> imem_addr=32'h3000, op=0, func=6'h20, instr_valid next cycle.
REQ-033 SHALL cover: ack delayed 3 cycles -> imem_req held high 4 cycles, imem_addr constant 32'h3000.
REQ-034 SHALL cover: pc=32'h3008, imm16=16'hFFFE, branch=1, zero=1 -> next pc=32'h3004; zero=0 -> 32'h300C.
REQ-035 SHALL cover: pc=32'h3010, IR[25:0]=26'h0000C10, Jump=1 and branch=1 -> next pc=32'h0000_3040.
REQ-036 SHALL cover: rst asserted during FETCH with imem_ack same cycle -> IR=0, pc=32'h3000, retired=0.
REQ-037 SHALL cover: RESET_PC=32'hFFFF_FFFC, one sequential retire -> pc=32'h0000_0000, retired=1.
